// File: rtl/warp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : warp_fifo
// Description : First-word-fall-through ready/valid FIFO with occupancy and
//               almost-full reporting and a synchronous flush.
// Revision    : 1.0 - initial release
// ============================================================================
module warp_fifo #(
    parameter int WIDTH        = 1,
    parameter int DEPTH        = 4,
    parameter int AFULL_MARGIN = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_input_valid,
    output logic                     o_input_ready,
    input  logic [WIDTH-1:0]         i_input_data,
    output logic                     o_output_valid,
    input  logic                     i_output_ready,
    output logic [WIDTH-1:0]         o_output_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_almost_full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_AFULL_LEVEL = (AW+1)'(DEPTH - AFULL_MARGIN);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_rd_idx;

    assign w_wr_idx = r_wr_ptr[AW-1:0];
    assign w_rd_idx = r_rd_ptr[AW-1:0];

    // Full when indices coincide but the writer has lapped the reader once.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (w_wr_idx == w_rd_idx) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

    assign o_input_ready  = !w_full;
    assign o_output_valid = !w_empty;

    // Flush overrides both handshakes so nothing is committed that cycle.
    assign w_push = i_input_valid  && o_input_ready  && !i_flush;
    assign w_pop  = o_output_valid && i_output_ready && !i_flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= r_wr_ptr;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[w_wr_idx] <= i_input_data;
        end
    end

    assign o_count       = r_wr_ptr - r_rd_ptr;
    assign o_almost_full = (o_count >= C_AFULL_LEVEL);
    assign o_output_data = w_empty ? '0 : r_mem[w_rd_idx];

endmodule
`default_nettype wire

// File: tb/tb_warp_fifo.sv
`default_nettype none
// Self-checking bench for warp_fifo: directed vector table, hand sequences
// for streaming and asynchronous reset, and a randomised scoreboard run.
module tb_warp_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int AFULL_MARGIN = 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       count;
    logic             afull;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    warp_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_MARGIN(AFULL_MARGIN)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_flush        (flush),
        .i_input_valid  (in_valid),
        .o_input_ready  (in_ready),
        .i_input_data   (in_data),
        .o_output_valid (out_valid),
        .i_output_ready (out_ready),
        .o_output_data  (out_data),
        .o_count        (count),
        .o_almost_full  (afull)
    );

    typedef struct {
        logic             flush;
        logic             valid;
        logic             ready;
        logic [WIDTH-1:0] data;
        logic             exp_in_ready;
        logic             exp_out_valid;
        logic [WIDTH-1:0] exp_data;
        logic [2:0]       exp_count;
        logic             exp_afull;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic rdy, input logic vld,
                             input logic [WIDTH-1:0] d, input logic [2:0] c, input logic af);
        check({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(vld));
        check({tag, ".out_data"}, 32'(out_data), 32'(d));
        check({tag, ".count"}, 32'(count), 32'(c));
        check({tag, ".afull"}, 32'(afull), 32'(af));
    endtask

    task automatic step(input logic f, input logic v, input logic r, input logic [WIDTH-1:0] d);
        @(negedge clk);
        flush = f; in_valid = v; out_ready = r; in_data = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            flush valid ready data     rdy  vld  data    cnt  af
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 16'hA,  1'b1, 1'b1, 16'hA,  3'd1, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 16'hB,  1'b1, 1'b1, 16'hA,  3'd2, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 16'hC,  1'b1, 1'b1, 16'hA,  3'd3, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 16'hD,  1'b0, 1'b1, 16'hA,  3'd4, 1'b1};
        // full: offered word E is refused, only the pop happens
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 16'hE,  1'b1, 1'b1, 16'hB,  3'd3, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 16'hE,  1'b1, 1'b1, 16'hC,  3'd3, 1'b1};
        // flush with concurrent push and pop
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 16'hF,  1'b1, 1'b0, 16'h0,  3'd0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 16'h11, 1'b1, 1'b1, 16'h11, 3'd1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 16'h0,  1'b1, 1'b0, 16'h0,  3'd0, 1'b0};
        // fill and drain across the pointer wrap
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 16'hA,  1'b1, 1'b1, 16'hA,  3'd1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 16'hB,  1'b1, 1'b1, 16'hA,  3'd2, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 16'hC,  1'b1, 1'b1, 16'hA,  3'd3, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 16'hD,  1'b0, 1'b1, 16'hA,  3'd4, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 16'h0,  1'b1, 1'b1, 16'hB,  3'd3, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 16'h0,  1'b1, 1'b1, 16'hC,  3'd2, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 16'h0,  1'b1, 1'b1, 16'hD,  3'd1, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 16'h0,  1'b1, 1'b0, 16'h0,  3'd0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 1'b1, 1'b0, 16'h0, 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].flush, vecs[i].valid, vecs[i].ready, vecs[i].data);
            check_all($sformatf("vec%0d", i), vecs[i].exp_in_ready, vecs[i].exp_out_valid,
                      vecs[i].exp_data, vecs[i].exp_count, vecs[i].exp_afull);
        end

        // Streaming at occupancy one: head always tracks the word just pushed.
        step(1'b0, 1'b1, 1'b0, 16'd1);
        check("stream.pre", 32'(out_data), 32'd1);
        for (int k = 2; k <= 21; k++) begin
            step(1'b0, 1'b1, 1'b1, 16'(k));
            check($sformatf("stream%0d.count", k), 32'(count), 32'd1);
            check($sformatf("stream%0d.data", k), 32'(out_data), 32'(k));
        end
        step(1'b0, 1'b0, 1'b1, 16'd0);
        check_all("stream.drain", 1'b1, 1'b0, 16'h0, 3'd0, 1'b0);

        // Asynchronous reset between edges with two entries held.
        step(1'b0, 1'b1, 1'b0, 16'h21);
        step(1'b0, 1'b1, 1'b0, 16'h22);
        check("rst.pre_count", 32'(count), 32'd2);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all("rst.async", 1'b1, 1'b0, 16'h0, 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b1, 16'h0);
        check_all("rst.after", 1'b1, 1'b0, 16'h0, 3'd0, 1'b0);

        // Random 50% valid/ready traffic against a queue model.
        begin
            logic [WIDTH-1:0] model[$];
            int sent = 0;
            int got = 0;
            int cycles = 0;
            while (got < 1000 && cycles < 20000) begin
                @(negedge clk);
                cycles++;
                in_valid  = (sent < 1000) && ($urandom_range(0, 1) == 1);
                in_data   = 16'(sent + 16'h100);
                out_ready = ($urandom_range(0, 1) == 1);
                flush     = 1'b0;
                #1;
                if (out_valid && out_ready) begin
                    if (model.size() == 0) begin
                        check("rand.unexpected_valid", 32'(out_valid), 32'd0);
                    end else begin
                        check("rand.data", 32'(out_data), 32'(model.pop_front()));
                    end
                    got++;
                end
                if (in_valid && in_ready) begin
                    model.push_back(in_data);
                    sent++;
                end
                @(posedge clk);
                #1;
                check("rand.count", 32'(count), 32'(model.size()));
            end
            check("rand.delivered", 32'(got), 32'd1000);
            in_valid = 1'b0;
            out_ready = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/warp_fifo.md
Name: warp_fifo

Overview:
- Parameterised synchronous ready/valid FIFO that buffers bursts between pipeline stages.
- Sits directly upstream of the pipeline skid buffer and feeds it: its output handshake connects straight to the skid buffer's input handshake.
- Absorbs producer bursts deeper than the skid buffer's single spare slot.
- Exposes occupancy and almost-full for upstream throttling, plus a synchronous flush for pipeline squash.

Parameters:
- WIDTH, 1, payload width in bits.
- DEPTH, 4, number of entries; power of two, minimum 2.
- AFULL_MARGIN, 1, o_almost_full asserts when free slots <= AFULL_MARGIN; legal range 0..DEPTH-1.

Ports:
- i_clk  input  1  clock, all state updates on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_flush  input  1  synchronous flush, discards all entries.
- i_input_valid  input  1  producer has data.
- o_input_ready  output  1  FIFO can accept data.
- i_input_data  input  WIDTH  producer payload.
- o_output_valid  output  1  head entry valid.
- i_output_ready  input  1  consumer accepts head.
- o_output_data  output  WIDTH  head payload.
- o_count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- o_almost_full  output  1  occupancy >= DEPTH-AFULL_MARGIN.

Behaviour:
- Clock is i_clk. Reset is i_rst_n, asynchronous assert, active-low.
- Reset values:
  - read/write pointers 0, o_count 0
  - o_input_ready 1, o_output_valid 0, o_output_data 0
  - o_almost_full 0 (for AFULL_MARGIN < DEPTH)
  - storage array is not reset.
- Pointers are $clog2(DEPTH)+1 bits with a wrap bit.
  - empty = pointers equal.
  - full = index bits equal and wrap bits differ.
  - o_count = wr_ptr - rd_ptr, modulo 2^(AW+1).
- Handshake terms:
  - push = i_input_valid && o_input_ready.
  - pop = o_output_valid && i_output_ready.
- Registered or combinational outputs:
  - o_input_ready = !full. Derived from registered pointers only; no combinational path from i_output_ready.
  - o_output_valid = !empty.
  - o_output_data = mem[rd_idx] when valid, else 0. First-word-fall-through, no combinational path from the input side.
- Latency: a word pushed at edge N is visible on o_output_valid/o_output_data after edge N. There is no same-cycle bypass when empty.
- Per-edge updates, in priority order:
  - i_flush: rd_ptr <= wr_ptr, count becomes 0. Any push or pop in the same cycle is ignored and the write is not committed.
  - push only: mem[wr_idx] <= data, wr_ptr++, count+1.
  - pop only: rd_ptr++, count-1.
  - push and pop: both pointers advance, count unchanged. Legal at any occupancy 1..DEPTH-1.
  - Full: push is impossible because ready is low. A pop on a full FIFO raises o_input_ready after the edge.
  - Empty: pop is impossible because valid is low.
- Wrap-around: indices roll from DEPTH-1 to 0 and the wrap bit toggles. Ordering is strictly FIFO across wrap.
- Stability: while o_output_valid && !i_output_ready, o_output_data holds, unless i_flush is asserted.
- Reset mid-operation: all contents are discarded immediately (asynchronous). The first cycle after release behaves as empty.
- Downstream compatibility: output timing is legal for the skid buffer input, which samples on registered ready.

Test Plan:
- Fill/drain: DEPTH=4, push 0xA,0xB,0xC,0xD with i_output_ready=0 -> after 4th edge o_input_ready=0, o_count=4, o_almost_full=1. Then ready=1 for 4 cycles -> outputs 0xA,0xB,0xC,0xD in order, o_count reaches 0, o_output_valid=0, o_output_data=0.
- Streaming: continuous valid and ready at count=1 for 20 cycles (pushes 1..20) -> count stays 1, outputs are sequential, no bubbles, pointers wrap 5 times without loss.
- Full with simultaneous pop: count=4, i_input_valid=1, i_output_ready=1 -> pop only, count=3 after edge. Next cycle push and pop -> count stays 3.
- Flush: count=3 with i_flush=1, i_input_valid=1, i_output_ready=1 -> after edge count=0, o_output_valid=0, pushed word is absent. The next push is the first word out.
- Reset mid-burst: count=2, assert i_rst_n=0 asynchronously between edges -> o_output_valid=0, o_input_ready=1, o_count=0 immediately without waiting for an edge.
- Chained with the skid buffer: random valid/ready at 50% duty over 1000 words -> scoreboard shows exact in-order delivery, no duplicates, no drops.
